// File: rtl/decoder_reg_n.sv
// decoder_reg_n: registered binary-to-one-hot decoder with valid/ready handshakes.
//
// A single output register holds one beat. An accepted beat decodes sel into a one-hot
// word (or all-zero when en=0, or all-zero with out_err when sel is out of range).
// An optional sweep engine, compiled in with DECODER_REG_N_SWEEP_EN, emits every code
// 0..NUM_OUT-1 in order through the same output register.
//
// Parameters:
//   SEL_W    width of the binary select
//   NUM_OUT  number of one-hot outputs, 2 <= NUM_OUT <= 2**SEL_W
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         input handshake carrying sel, en
//   out_valid/out_ready       output handshake carrying out_onehot, out_err
//   sweep_start, sweep_busy   sweep request pulse and in-progress flag
// Macro:
//   DECODER_REG_N_SWEEP_EN    compiles in the sweep FSM; otherwise sweep_busy is 0
module decoder_reg_n #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned NUM_OUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic               en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_onehot,
  output logic               out_err,
  input  logic               sweep_start,
  output logic               sweep_busy
);

  logic               out_valid_q;
  logic [NUM_OUT-1:0] out_onehot_q;
  logic               out_err_q;

  logic               can_load;
  logic               in_xfer;
  logic [NUM_OUT-1:0] dec_onehot;
  logic               dec_err;
  logic               sweep_load;
  logic [NUM_OUT-1:0] sweep_onehot;

  // The register can take a new beat when empty or when its beat leaves this cycle.
  assign can_load = !out_valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;

  // Compare in 32 bits so NUM_OUT == 2**SEL_W needs no special case.
  always_comb begin
    dec_onehot = '0;
    dec_err    = en && (32'(sel) >= NUM_OUT);
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (en && (32'(sel) == i)) begin
        dec_onehot[i] = 1'b1;
      end
    end
  end

`ifdef DECODER_REG_N_SWEEP_EN
  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e           state_q;
  logic [SEL_W-1:0] cnt_q;
  logic             cnt_last;

  assign cnt_last   = (32'(cnt_q) == (NUM_OUT - 1));
  assign in_ready   = can_load && (state_q == StIdle);
  assign sweep_busy = (state_q == StSweep);
  assign sweep_load = (state_q == StSweep) && can_load;

  always_comb begin
    sweep_onehot = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (32'(cnt_q) == i) begin
        sweep_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          // A same-cycle input transfer wins; the request is dropped, not queued.
          if (sweep_start && !in_xfer) begin
            state_q <= StSweep;
          end
        end
        StSweep: begin
          if (can_load) begin
            if (cnt_last) begin
              cnt_q   <= '0;
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + SEL_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
`else
  logic unused_sweep_start;

  assign unused_sweep_start = sweep_start;
  assign in_ready           = can_load;
  assign sweep_busy         = 1'b0;
  assign sweep_load         = 1'b0;
  assign sweep_onehot       = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_onehot_q <= '0;
      out_err_q    <= 1'b0;
    end else if (in_xfer) begin
      out_valid_q  <= 1'b1;
      out_onehot_q <= dec_onehot;
      out_err_q    <= dec_err;
    end else if (sweep_load) begin
      out_valid_q  <= 1'b1;
      out_onehot_q <= sweep_onehot;
      out_err_q    <= 1'b0;
    end else if (out_valid_q && out_ready) begin
      // Data fields keep their last values once the beat has gone.
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_onehot = out_onehot_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_decoder_reg_n.sv
module tb_decoder_reg_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] sel;
  logic       en;
  logic       out_ready;
  logic       sweep_start;

  logic       in_ready8, out_valid8, out_err8, sweep_busy8;
  logic [7:0] out_onehot8;
  logic       in_ready6, out_valid6, out_err6, sweep_busy6;
  logic [5:0] out_onehot6;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_reg_n #(.SEL_W(3), .NUM_OUT(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready8),
    .sel        (sel),
    .en         (en),
    .out_valid  (out_valid8),
    .out_ready  (out_ready),
    .out_onehot (out_onehot8),
    .out_err    (out_err8),
    .sweep_start(sweep_start),
    .sweep_busy (sweep_busy8)
  );

  decoder_reg_n #(.SEL_W(3), .NUM_OUT(6)) u_dut6 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready6),
    .sel        (sel),
    .en         (en),
    .out_valid  (out_valid6),
    .out_ready  (out_ready),
    .out_onehot (out_onehot6),
    .out_err    (out_err6),
    .sweep_start(sweep_start),
    .sweep_busy (sweep_busy6)
  );

  typedef struct {
    logic       in_valid;
    logic [2:0] sel;
    logic       en;
    logic       out_ready;
    logic       exp_in_ready;
    logic       exp_valid;
    logic [7:0] exp_onehot;
    logic       exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [2:0] s, input logic e, input logic ordy);
    in_valid  = iv;
    sel       = s;
    en        = e;
    out_ready = ordy;
  endtask

  function automatic vec_t mk(input logic iv, input logic [2:0] s, input logic e,
                              input logic ordy, input logic xr, input logic xv,
                              input logic [7:0] xo, input logic xe);
    vec_t v;
    v.in_valid = iv; v.sel = s; v.en = e; v.out_ready = ordy;
    v.exp_in_ready = xr; v.exp_valid = xv; v.exp_onehot = xo; v.exp_err = xe;
    return v;
  endfunction

  // Inputs are driven 1 time unit after the rising edge; combinational outputs are
  // checked on the falling edge, registered outputs 1 unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_code;
    int mcode;
    logic mvalid;
    logic load;

    rst = 1'b1;
    sweep_start = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset out_valid", 32'(out_valid8), 32'd0);
    chk("reset out_onehot", 32'(out_onehot8), 32'd0);
    chk("reset out_err", 32'(out_err8), 32'd0);
    chk("reset sweep_busy", 32'(sweep_busy8), 32'd0);
    chk("reset in_ready", 32'(in_ready8), 32'd1);

    // Stream sel 0..7, then en=0, then idle cycles.
    for (int k = 0; k < 8; k++) begin
      vecs[k] = mk(1'b1, 3'(k), 1'b1, 1'b1, 1'b1, 1'b1, 8'(1 << k), 1'b0);
    end
    vecs[8]  = mk(1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    vecs[9]  = mk(1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0);
    vecs[10] = mk(1'b0, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 1'b0);
    vecs[11] = mk(1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 1'b0);
    vecs[12] = mk(1'b1, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].in_valid, vecs[i].sel, vecs[i].en, vecs[i].out_ready);
      @(negedge clk);
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready8), 32'(vecs[i].exp_in_ready));
      tick();
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid8), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d out_onehot", i), 32'(out_onehot8), 32'(vecs[i].exp_onehot));
      chk($sformatf("vec%0d out_err", i), 32'(out_err8), 32'(vecs[i].exp_err));
    end

    // Drain the beat left by the last vector.
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    tick();
    chk("drain out_valid", 32'(out_valid8), 32'd0);

    // NUM_OUT=6: last legal code, then first out-of-range code.
    drive(1'b1, 3'd5, 1'b1, 1'b1);
    tick();
    chk("n6 sel5 onehot", 32'(out_onehot6), 32'h20);
    chk("n6 sel5 err", 32'(out_err6), 32'd0);
    drive(1'b1, 3'd6, 1'b1, 1'b1);
    tick();
    chk("n6 sel6 onehot", 32'(out_onehot6), 32'h00);
    chk("n6 sel6 err", 32'(out_err6), 32'd1);
    chk("n6 sel6 valid", 32'(out_valid6), 32'd1);
    drive(1'b1, 3'd7, 1'b0, 1'b1);
    tick();
    chk("n6 sel7 en0 err", 32'(out_err6), 32'd0);

    // Back-pressure: 0x04 held for 4 cycles while sel=7 waits.
    drive(1'b1, 3'd2, 1'b1, 1'b1);
    tick();
    chk("stall load 0x04", 32'(out_onehot8), 32'h04);
    drive(1'b1, 3'd7, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d in_ready", c), 32'(in_ready8), 32'd0);
      tick();
      chk($sformatf("stall%0d onehot", c), 32'(out_onehot8), 32'h04);
      chk($sformatf("stall%0d valid", c), 32'(out_valid8), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release in_ready", 32'(in_ready8), 32'd1);
    tick();
    chk("release onehot", 32'(out_onehot8), 32'h80);
    chk("release valid", 32'(out_valid8), 32'd1);
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    tick();
    chk("release drain", 32'(out_valid8), 32'd0);

`ifdef DECODER_REG_N_SWEEP_EN
    // Full-throughput sweep.
    sweep_start = 1'b1;
    @(negedge clk);
    chk("sweep pre busy", 32'(sweep_busy8), 32'd0);
    tick();
    sweep_start = 1'b0;
    chk("sweep accepted busy", 32'(sweep_busy8), 32'd1);
    chk("sweep accepted valid", 32'(out_valid8), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("sweep%0d in_ready", k), 32'(in_ready8), 32'd0);
      tick();
      chk($sformatf("sweep%0d onehot", k), 32'(out_onehot8), 32'(1 << k));
      chk($sformatf("sweep%0d valid", k), 32'(out_valid8), 32'd1);
      chk($sformatf("sweep%0d busy", k), 32'(sweep_busy8), (k != 7) ? 32'd1 : 32'd0);
    end
    tick();
    chk("sweep drain", 32'(out_valid8), 32'd0);

    // Sweep with toggling out_ready and a blocked input request.
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    exp_code = 0;
    mcode = 0;
    mvalid = 1'b0;
    for (int c = 0; c < 40 && exp_code < 8; c++) begin
      drive(1'b1, 3'd5, 1'b1, (c % 3) != 1);
      load = !mvalid || out_ready;
      @(negedge clk);
      chk("bp sweep in_ready", 32'(in_ready8), 32'd0);
      tick();
      if (load) begin
        mcode = exp_code;
        exp_code++;
        mvalid = 1'b1;
      end
      chk("bp sweep onehot", 32'(out_onehot8), 32'(1 << mcode));
      chk("bp sweep valid", 32'(out_valid8), 32'(mvalid));
      chk("bp sweep busy", 32'(sweep_busy8), (exp_code < 8) ? 32'd1 : 32'd0);
    end
    chk("bp sweep completed", 32'(exp_code), 32'd8);
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    tick();

    // An input transfer on the same edge wins and the request is dropped.
    drive(1'b1, 3'd1, 1'b1, 1'b1);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    chk("race onehot", 32'(out_onehot8), 32'h02);
    chk("race busy", 32'(sweep_busy8), 32'd0);
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    tick();
    chk("race not queued", 32'(sweep_busy8), 32'd0);
    chk("race drain", 32'(out_valid8), 32'd0);

    // Reset mid-sweep with code 4 on the output.
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    repeat (5) tick();
    chk("mid onehot", 32'(out_onehot8), 32'h10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst mid valid", 32'(out_valid8), 32'd0);
    chk("rst mid onehot", 32'(out_onehot8), 32'd0);
    chk("rst mid busy", 32'(sweep_busy8), 32'd0);
    chk("rst mid in_ready", 32'(in_ready8), 32'd1);
`else
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("nosweep busy", 32'(sweep_busy8), 32'd0);
    chk("nosweep valid", 32'(out_valid8), 32'd0);
    chk("nosweep in_ready", 32'(in_ready8), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_reg_n.md
# decoder_reg_n

Parametrised, registered binary-to-one-hot decoder with valid/ready handshakes on input and output and a configurable number of outputs. It is the next generation of the team's fixed 3-to-8 combinational decoder. It sits between a control-path producer, such as a command or address decoder front end, and the one-hot select lines of downstream banks. An optional sweep engine walks every output code in turn for bring-up and self-test.

## Interface
Parameters:
- SEL_W, 3: width of the binary select input.
- NUM_OUT, 8: number of one-hot outputs. Legal range is 2 ≤ NUM_OUT ≤ 2^SEL_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  sel/en beat offered.
- in_ready  output  1  block accepts a beat this cycle.
- sel  input  SEL_W  binary code to decode.
- en  input  1  decode enable; 0 produces an all-zero beat.
- out_valid  output  1  out_onehot/out_err hold a beat.
- out_ready  input  1  consumer takes the beat.
- out_onehot  output  NUM_OUT  registered one-hot result.
- out_err  output  1  beat had sel ≥ NUM_OUT.
- sweep_start  input  1  single-cycle request to start a sweep.
- sweep_busy  output  1  sweep in progress.

## Operation
- Handshake: a transfer occurs when valid and ready are both 1 on a rising clk edge.
- in_ready = !out_valid || out_ready. This is a single-stage register; full throughput is one beat per cycle.
- On an input transfer, the output register loads:
  - en=1 and sel < NUM_OUT: out_onehot = 1 << sel; out_err = 0.
  - en=1 and sel ≥ NUM_OUT: out_onehot = 0; out_err = 1.
  - en=0: out_onehot = 0; out_err = 0. The beat is still delivered.
- out_onehot is always zero or exactly one-hot; never more than one bit is set.
- When no input transfer happens and an output transfer does, out_valid clears. out_onehot and out_err keep their last values.
- While out_valid=1 and out_ready=0, out_onehot and out_err are held stable.
- Simultaneous output transfer and input transfer: the new beat replaces the old with no bubble.
- Sweep FSM (present only with the macro), states IDLE and SWEEP:
  - IDLE→SWEEP when sweep_start=1 and no input transfer is occurring that cycle. An input transfer on the same cycle wins; sweep_start is then dropped, not queued.
  - In SWEEP: in_ready=0 and sweep_busy=1. The FSM emits beats with codes 0,1,…,NUM_OUT-1 in order, using the same output handshake rules, with en=1 and out_err=0.
  - SWEEP→IDLE on the output-register load of code NUM_OUT-1. sweep_busy drops the cycle after that load.
  - sweep_start is ignored while in SWEEP.
- rst at any time, including mid-sweep or with a beat stalled, discards all pending state.

## Timing
- Reset values: out_valid=0, out_onehot=0, out_err=0, sweep_busy=0, FSM=IDLE, sweep counter=0.
- in_ready reads as 1 in the first cycle after reset.
- Latency: an input accepted at edge N appears on out_valid/out_onehot after edge N; the consumer can take it at edge N+1.
- in_ready is combinational from out_valid, out_ready and FSM state only. There is no combinational path from in_valid or sel to any output.
- Sweep timing:
  - sweep_start accepted at edge N: sweep_busy=1 after N; code 0 is loaded at edge N+1.
  - With out_ready held at 1, codes are loaded on consecutive edges. The final code NUM_OUT-1 is loaded at edge N+NUM_OUT, and sweep_busy=0 after edge N+NUM_OUT.
  - Back-pressure stretches the sweep without skipping or repeating any code.

## Configuration
- DECODER_REG_N_SWEEP_EN defined: the sweep FSM and counter are compiled in and behave as above.
- DECODER_REG_N_SWEEP_EN undefined:
  - The sweep logic is absent.
  - sweep_start is ignored and sweep_busy is tied to 0.
  - in_ready = !out_valid || out_ready unconditionally.
  - All other behaviour is unchanged.

## Test plan
- SEL_W=3, NUM_OUT=8, out_ready=1; stream sel=0..7 with en=1, one per cycle → out_onehot = 0x01,0x02,…,0x80 on consecutive cycles, out_err=0, in_ready stays 1.
- SEL_W=3, NUM_OUT=6; send sel=5 then sel=6, en=1 → 0x20 with out_err=0, then 0x00 with out_err=1.
- Send sel=3, en=0 → out_valid=1, out_onehot=0x00, out_err=0.
- Hold out_ready=0 for 4 cycles after sel=2 (0x04) is loaded, while in_valid=1 with sel=7 → in_ready=0 and out_onehot stays 0x04. Raise out_ready → 0x80 is loaded on the same edge that 0x04 transfers.
- Macro on, NUM_OUT=8; pulse sweep_start with out_ready=1 → codes 0x01…0x80 on 8 consecutive cycles, sweep_busy high for 8 cycles, in_ready=0 throughout. Repeat with out_ready toggling → the same ordered sequence with no gaps or duplicates.
- Assert rst for one cycle mid-sweep at code 4 with out_valid=1 → the next cycle has out_valid=0, out_onehot=0, sweep_busy=0, in_ready=1.
